// File: rtl/traffic_ctrl_param_if.sv
// Signal bundle for the parametrised intersection controller:
// mode/request inputs in, head codes and debug phase out.
interface traffic_ctrl_param_if;
  logic       night;
  logic       ped_req_h;
  logic       ped_req_v;
  logic [2:0] h_car_traffic;
  logic [2:0] v_car_traffic;
  logic [2:0] h_walker_traffic;
  logic [2:0] v_walker_traffic;
  logic [3:0] phase;

  modport master (
    output night, ped_req_h, ped_req_v,
    input  h_car_traffic, v_car_traffic,
    input  h_walker_traffic, v_walker_traffic,
    input  phase
  );

  modport slave (
    input  night, ped_req_h, ped_req_v,
    output h_car_traffic, v_car_traffic,
    output h_walker_traffic, v_walker_traffic,
    output phase
  );
endinterface

// File: rtl/traffic_ctrl_param.sv
// Actuated 8-phase intersection controller with latched walker
// requests, night flashing and an all-red recovery phase.
module traffic_ctrl_param #(
  parameter int unsigned T_GREEN      = 20,
  parameter int unsigned T_YELLOW     = 2,
  parameter int unsigned T_LEFT       = 10,
  parameter int unsigned T_TWINKLE    = 6,
  parameter int unsigned T_BLINK      = 1,
  parameter bit          PED_ACTUATED = 1'b0,
  parameter int unsigned CNT_W        = 8
) (
  input logic clk,
  input logic rst,
  traffic_ctrl_param_if.slave bus
);

  typedef enum logic [3:0] {
    H_GREEN = 4'd0,
    H_YEL1  = 4'd1,
    H_LEFT  = 4'd2,
    H_YEL2  = 4'd3,
    V_GREEN = 4'd4,
    V_YEL1  = 4'd5,
    V_LEFT  = 4'd6,
    V_YEL2  = 4'd7,
    NIGHT   = 4'd8,
    ALL_RED = 4'd9
  } phase_t;

  typedef enum logic [2:0] {
    RED     = 3'b000,
    GREEN   = 3'b001,
    YELLOW  = 3'b010,
    LEFT    = 3'b011,
    TWINKLE = 3'b100,
    OFF     = 3'b101
  } light_t;

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(T_LEFT - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(T_BLINK - 1);
  localparam logic [CNT_W:0]   WALK_N =
    (CNT_W+1)'(T_GREEN - T_TWINKLE);
  localparam light_t V_WALK_RST =
    PED_ACTUATED ? RED :
    (T_GREEN > T_TWINKLE) ? GREEN : TWINKLE;

  phase_t           ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_h_q, pend_h_d;
  logic             pend_v_q, pend_v_d;
  logic             serve_h_q, serve_h_d;
  logic             serve_v_q, serve_v_d;
  logic             blink_q, blink_d;
  logic             hold_q;
  logic             last;
  logic             walk;
  light_t           h_car_q, h_car_d;
  light_t           v_car_q, v_car_d;
  light_t           h_walk_q, h_walk_d;
  light_t           v_walk_q, v_walk_d;

  // Reset asserts asynchronously but its release is retimed to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= 1'b1;
    else     hold_q <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q      <= H_GREEN;
      cnt_q     <= '0;
      pend_h_q  <= 1'b0;
      pend_v_q  <= 1'b0;
      serve_h_q <= ~PED_ACTUATED;
      serve_v_q <= ~PED_ACTUATED;
      blink_q   <= 1'b0;
      h_car_q   <= GREEN;
      v_car_q   <= RED;
      h_walk_q  <= RED;
      v_walk_q  <= V_WALK_RST;
    end else begin
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      pend_h_q  <= pend_h_d;
      pend_v_q  <= pend_v_d;
      serve_h_q <= serve_h_d;
      serve_v_q <= serve_v_d;
      blink_q   <= blink_d;
      h_car_q   <= h_car_d;
      v_car_q   <= v_car_d;
      h_walk_q  <= h_walk_d;
      v_walk_q  <= v_walk_d;
    end
  end

  always_comb begin
    ph_d      = ph_q;
    cnt_d     = cnt_q + CNT_W'(1);
    pend_h_d  = pend_h_q | bus.ped_req_h;
    pend_v_d  = pend_v_q | bus.ped_req_v;
    serve_h_d = serve_h_q;
    serve_v_d = serve_v_q;
    blink_d   = blink_q;
    last      = 1'b0;
    h_car_d   = RED;
    v_car_d   = RED;
    h_walk_d  = RED;
    v_walk_d  = RED;

    unique case (ph_q)
      H_GREEN, V_GREEN: last = (cnt_q == G_LAST);
      H_LEFT, V_LEFT:   last = (cnt_q == L_LAST);
      NIGHT:            last = (cnt_q == B_LAST);
      default:          last = (cnt_q == Y_LAST);
    endcase

    if (last) begin
      cnt_d = '0;
      unique case (ph_q)
        H_YEL2: begin
          ph_d    = bus.night ? NIGHT : V_GREEN;
          blink_d = 1'b0;
        end
        V_YEL2: begin
          ph_d    = bus.night ? NIGHT : H_GREEN;
          blink_d = 1'b0;
        end
        NIGHT: begin
          blink_d = ~blink_q;
          if (!bus.night) ph_d = ALL_RED;
        end
        ALL_RED: ph_d = H_GREEN;
        H_GREEN, H_YEL1, H_LEFT,
        V_GREEN, V_YEL1, V_LEFT:
          ph_d = phase_t'(ph_q + 4'd1);
        default: ph_d = ALL_RED;
      endcase
      // Serving decision is taken from requests latched before entry
      if (ph_d == H_GREEN) begin
        serve_v_d = pend_v_q | ~PED_ACTUATED;
        pend_v_d  = bus.ped_req_v;
      end
      if (ph_d == V_GREEN) begin
        serve_h_d = pend_h_q | ~PED_ACTUATED;
        pend_h_d  = bus.ped_req_h;
      end
    end

    if (hold_q) begin
      ph_d      = H_GREEN;
      cnt_d     = '0;
      pend_h_d  = 1'b0;
      pend_v_d  = 1'b0;
      serve_h_d = ~PED_ACTUATED;
      serve_v_d = ~PED_ACTUATED;
      blink_d   = 1'b0;
    end

    walk = ({1'b0, cnt_d} < WALK_N);

    unique case (ph_d)
      H_GREEN: begin
        h_car_d = GREEN;
        if (serve_v_d) v_walk_d = walk ? GREEN : TWINKLE;
      end
      H_YEL1, H_YEL2: h_car_d = YELLOW;
      H_LEFT:         h_car_d = LEFT;
      V_GREEN: begin
        v_car_d = GREEN;
        if (serve_h_d) h_walk_d = walk ? GREEN : TWINKLE;
      end
      V_YEL1, V_YEL2: v_car_d = YELLOW;
      V_LEFT:         v_car_d = LEFT;
      NIGHT: begin
        h_car_d  = blink_d ? OFF : YELLOW;
        v_car_d  = blink_d ? OFF : YELLOW;
        h_walk_d = OFF;
        v_walk_d = OFF;
      end
      default: ;
    endcase
  end

  assign bus.h_car_traffic    = h_car_q;
  assign bus.v_car_traffic    = v_car_q;
  assign bus.h_walker_traffic = h_walk_q;
  assign bus.v_walker_traffic = v_walk_q;
  assign bus.phase            = ph_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Scoreboard bench: three controller configurations share stimulus
// and are checked every cycle against a phase-timeline model.
module tb_traffic_ctrl_param;

  localparam logic [2:0] R  = 3'b000;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] L  = 3'b011;
  localparam logic [2:0] TW = 3'b100;
  localparam logic [2:0] OF = 3'b101;

  logic clk;
  logic rst;
  logic night, rh, rv;

  int tg[3]  = '{20, 20, 5};
  int ty[3]  = '{2, 2, 1};
  int tl[3]  = '{10, 10, 1};
  int tt[3]  = '{6, 6, 2};
  int tb[3]  = '{1, 1, 2};
  bit ped[3] = '{1'b0, 1'b1, 1'b1};

  int m_ph[3], m_el[3], m_ne[3];
  bit m_ph_req[3], m_pv[3], m_sh[3], m_sv[3];

  logic [47:0] q[$];
  bit mon_en;
  int n_chk, n_err, cyc;

  traffic_ctrl_param_if bus0 ();
  traffic_ctrl_param_if bus1 ();
  traffic_ctrl_param_if bus2 ();

  assign bus0.night = night;
  assign bus0.ped_req_h = rh;
  assign bus0.ped_req_v = rv;
  assign bus1.night = night;
  assign bus1.ped_req_h = rh;
  assign bus1.ped_req_v = rv;
  assign bus2.night = night;
  assign bus2.ped_req_h = rh;
  assign bus2.ped_req_v = rv;

  traffic_ctrl_param #(.PED_ACTUATED(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  traffic_ctrl_param #(.PED_ACTUATED(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  traffic_ctrl_param #(
    .T_GREEN(5), .T_YELLOW(1), .T_LEFT(1), .T_TWINKLE(2),
    .T_BLINK(2), .PED_ACTUATED(1'b1), .CNT_W(3)
  ) u2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  logic [15:0] act[3];
  assign act[0] = {bus0.h_car_traffic, bus0.v_car_traffic,
                   bus0.h_walker_traffic, bus0.v_walker_traffic,
                   bus0.phase};
  assign act[1] = {bus1.h_car_traffic, bus1.v_car_traffic,
                   bus1.h_walker_traffic, bus1.v_walker_traffic,
                   bus1.phase};
  assign act[2] = {bus2.h_car_traffic, bus2.v_car_traffic,
                   bus2.h_walker_traffic, bus2.v_walker_traffic,
                   bus2.phase};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dur(int i, int p);
    case (p)
      0, 4:    return tg[i];
      2, 6:    return tl[i];
      default: return ty[i];
    endcase
  endfunction

  function automatic logic [15:0] expv(int i);
    logic [2:0] hc, vc, hw, vw;
    hc = R; vc = R; hw = R; vw = R;
    case (m_ph[i])
      0: begin
        hc = G;
        if (m_sv[i]) vw = (m_el[i] < tg[i] - tt[i]) ? G : TW;
      end
      1, 3: hc = Y;
      2:    hc = L;
      4: begin
        vc = G;
        if (m_sh[i]) hw = (m_el[i] < tg[i] - tt[i]) ? G : TW;
      end
      5, 7: vc = Y;
      6:    vc = L;
      8: begin
        hc = ((m_ne[i] / tb[i]) % 2 == 0) ? Y : OF;
        vc = hc;
        hw = OF;
        vw = OF;
      end
      default: ;
    endcase
    return {hc, vc, hw, vw, 4'(m_ph[i])};
  endfunction

  function automatic logic [47:0] pack();
    return {expv(2), expv(1), expv(0)};
  endfunction

  function automatic void model_reset(int i);
    m_ph[i] = 0; m_el[i] = 0; m_ne[i] = 0;
    m_ph_req[i] = 1'b0; m_pv[i] = 1'b0;
    m_sh[i] = !ped[i]; m_sv[i] = !ped[i];
  endfunction

  function automatic void model_step(int i, bit n, bit a, bit b);
    int old;
    old = m_ph[i];
    if (old == 8) begin
      if (m_ne[i] % tb[i] == tb[i] - 1 && !n) begin
        m_ph[i] = 9; m_el[i] = 0;
      end else m_ne[i]++;
    end else if (m_el[i] == dur(i, old) - 1) begin
      m_el[i] = 0;
      if ((old == 3 || old == 7) && n) begin
        m_ph[i] = 8; m_ne[i] = 0;
      end else if (old == 9) m_ph[i] = 0;
      else m_ph[i] = (old + 1) % 8;
    end else m_el[i]++;
    if (m_ph[i] == 0 && old != 0) begin
      m_sv[i] = m_pv[i] | !ped[i];
      m_pv[i] = b;
    end else m_pv[i] = m_pv[i] | b;
    if (m_ph[i] == 4 && old != 4) begin
      m_sh[i] = m_ph_req[i] | !ped[i];
      m_ph_req[i] = a;
    end else m_ph_req[i] = m_ph_req[i] | a;
  endfunction

  task automatic check_reset(string nm);
    logic [15:0] want;
    for (int i = 0; i < 3; i++) begin
      want = {G, R, R, (ped[i] ? R : G), 4'd0};
      n_chk++;
      if (act[i] !== want) begin
        n_err++;
        $display("FAIL %s u%0d got %h want %h", nm, i, act[i], want);
      end
    end
  endtask

  task automatic release_rst();
    rst = 1'b0; night = 1'b0; rh = 1'b0; rv = 1'b0;
    for (int i = 0; i < 3; i++) model_reset(i);
    q.push_back(pack());
    mon_en = 1'b1;
  endtask

  task automatic cycle(bit n, bit a, bit b);
    @(negedge clk);
    night = n; rh = a; rv = b; cyc++;
    for (int i = 0; i < 3; i++) model_step(i, n, a, b);
    q.push_back(pack());
  endtask

  task automatic run(int len, int mode, int rq);
    bit n, a, b;
    for (int k = 0; k < len; k++) begin
      n = (mode == 1) ? 1'b1 :
          (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      a = (rq != 0) && ($urandom_range(0, rq - 1) == 0);
      b = (rq != 0) && ($urandom_range(0, rq - 1) == 0);
      cycle(n, a, b);
    end
  endtask

  task automatic mid_reset();
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      hit = (m_ph[0] == 2 && m_el[0] == 4);
    end
    n_chk++;
    if (!hit) begin
      n_err++;
      $display("FAIL h_left_wait got timeout want phase 2");
    end
    #3;
    rst = 1'b1;
    q.delete();
    mon_en = 1'b0;
    #1 check_reset("rst_async");
    @(negedge clk);
    check_reset("rst_held");
    release_rst();
  endtask

  initial begin
    logic [47:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL scoreboard got empty want entry");
        end else begin
          e = q.pop_front();
          for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (act[i] !== e[i*16 +: 16]) begin
              n_err++;
              $display("FAIL lights u%0d cyc %0d got %h want %h",
                       i, cyc, act[i], e[i*16 +: 16]);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; night = 1'b0; rh = 1'b0; rv = 1'b0;
    mon_en = 1'b0; n_chk = 0; n_err = 0; cyc = 0;
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    release_rst();
    run(40, 0, 0);
    cycle(1'b0, 1'b0, 1'b1);
    run(4, 0, 0);
    cycle(1'b0, 1'b1, 1'b0);
    run(94, 0, 0);
    run(6, 0, 0);
    run(150, 1, 12);
    run(100, 0, 12);
    mid_reset();
    for (int s = 0; s < 14; s++)
      run($urandom_range(20, 200), $urandom_range(0, 2), 10);
    mid_reset();
    run(200, 2, 6);
    run(100, 0, 0);
    @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
